// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for the multiply-accumulate datapath.
// Pulls a job of len operand pairs through a valid/ready input stream,
// multiplies each pair in a registered product stage, accumulates the
// products and presents the final sum on a held valid/ready result port.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds its payload stable
// while valid is high and not yet taken; ready never depends on valid.
// in_ready is high only in RUN. out_valid is high only in DONE, and result
// stays stable until the transfer.
module mac_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 ovf,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   ovf_q;
  logic [2*WIDTH-1:0]     p_reg_q;
  logic                   p_vld_q;
  logic [LEN_WIDTH-1:0]   count_q;
  logic [LEN_WIDTH-1:0]   len_q;

  logic                   start_take;
  logic                   accept;
  logic                   last_accept;
  logic [LEN_WIDTH:0]     count_inc;
  logic [2*WIDTH-1:0]     prod;
  logic [ACC_WIDTH:0]     acc_sum;

  // Full-width unsigned product; operands are zero-extended first.
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // One extra bit on the sum exposes the carry-out that feeds ovf.
  assign acc_sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, p_reg_q};

  // count is widened so count+1 cannot wrap before the compare with len.
  assign count_inc   = {1'b0, count_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign start_take  = (state_q == S_IDLE) && start;
  assign accept      = in_ready && in_valid;
  assign last_accept = accept && (count_inc == {1'b0, len_q});

  assign result    = acc_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and port decode.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (last_accept) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last product is added on this edge.
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Product stage: one registered product per accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg_q <= '0;
      p_vld_q <= 1'b0;
    end else begin
      p_vld_q <= accept;
      if (accept) begin
        p_reg_q <= prod;
      end
    end
  end

  // Job bookkeeping: length captured at start, pairs counted on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      len_q   <= '0;
    end else if (start_take) begin
      count_q <= '0;
      len_q   <= len;
    end else if (accept) begin
      count_q <= count_inc[LEN_WIDTH-1:0];
    end
  end

  // Accumulator and sticky overflow; both survive until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_take) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (p_vld_q) begin
      acc_q <= acc_sum[ACC_WIDTH-1:0];
      if (acc_sum[ACC_WIDTH]) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: one task per scenario, expected
// {ovf, result} pairs queued as jobs are driven and popped at the result.
module tb_mac_seq_ctrl;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 16;
  localparam int LEN_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [LEN_WIDTH-1:0] len = '0;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     a_in = '0;
  logic [WIDTH-1:0]     b_in = '0;
  logic                 out_ready = 1'b0;
  logic                 busy;
  logic                 in_ready;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] result;
  logic                 ovf;
  logic [1:0]           state_dbg;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  longint model_total = 0;
  logic [ACC_WIDTH:0] exp_q[$];

  mac_seq_ctrl #(
    .WIDTH(WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .busy(busy),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a_in),
    .b(b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .ovf(ovf),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count pairs that will be taken on the coming rising edge.
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
  end

  // ---------------- driver tasks ----------------

  task automatic wait_idle(input string tag);
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  // Returns #1 after the edge that took start.
  task automatic start_job(input int n, input string tag);
    wait_idle(tag);
    @(posedge clk);
    #1;
    start = 1'b1;
    len = LEN_WIDTH'(n);
    model_total = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    len = '0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_after_start: busy=%b required 1", tag, busy);
    end
  endtask

  // Offers one pair and returns #1 after the edge that accepts it.
  task automatic send_pair(input int av, input int bv, output int waited, input string tag);
    a_in = WIDTH'(av);
    b_in = WIDTH'(bv);
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept_timeout: in_ready=%b required 1", tag, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_total += longint'(av) * longint'(bv);
  endtask

  task automatic expect_job();
    logic [ACC_WIDTH:0] e;
    e[ACC_WIDTH] = (model_total >= (longint'(1) << ACC_WIDTH));
    e[ACC_WIDTH-1:0] = ACC_WIDTH'(model_total % (longint'(1) << ACC_WIDTH));
    exp_q.push_back(e);
  endtask

  // Scoreboard side: waits for out_valid, checks latency, holds out_ready
  // low for 'hold' cycles, compares against the queue, then handshakes.
  task automatic collect(input int exp_lat, input int hold, input string tag);
    int lat = 0;
    logic [ACC_WIDTH:0] e;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_result_timeout: out_valid=%b required 1", tag, out_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges required %0d", tag, lat, exp_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_queue_empty: got result %0d with nothing expected", tag, result);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== e[ACC_WIDTH-1:0]) begin
        failures++;
        $display("FAIL %s_hold%0d: out_valid=%b result=%0d required 1/%0d",
                 tag, i, out_valid, result, e[ACC_WIDTH-1:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (result !== e[ACC_WIDTH-1:0]) begin
      failures++;
      $display("FAIL %s_result: got %0d required %0d", tag, result, e[ACC_WIDTH-1:0]);
    end
    checks++;
    if (ovf !== e[ACC_WIDTH]) begin
      failures++;
      $display("FAIL %s_ovf: got %b required %b", tag, ovf, e[ACC_WIDTH]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: out_valid=%b busy=%b required 0/0", tag, out_valid, busy);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got %b required 0", tag, busy);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_in_ready: got %b required 0", tag, in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_out_valid: got %b required 0", tag, out_valid);
    end
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL %s_result: got %0d required 0", tag, result);
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL %s_ovf: got %b required 0", tag, ovf);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL %s_state: got %0d required 0", tag, state_dbg);
    end
  endtask

  // ---------------- scenarios ----------------

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int w;
    start_job(3, "midrst");
    send_pair(3, 4, w, "midrst");
    send_pair(5, 6, w, "midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int w;
    start_job(3, "basic");
    send_pair(3, 4, w, "basic");
    send_pair(5, 6, w, "basic");
    send_pair(7, 8, w, "basic");
    expect_job();
    collect(2, 0, "basic");
  endtask

  task automatic test_stall_backpressure();
    int w;
    int base;
    base = acc_cnt;
    start_job(3, "stall");
    send_pair(3, 4, w, "stall");
    repeat (2) @(posedge clk);
    #1;
    send_pair(5, 6, w, "stall");
    repeat (2) @(posedge clk);
    #1;
    send_pair(7, 8, w, "stall");
    expect_job();
    in_valid = 1'b1;
    a_in = 8'd9;
    b_in = 8'd9;
    collect(2, 4, "stall");
    in_valid = 1'b0;
    checks++;
    if (acc_cnt - base !== 3) begin
      failures++;
      $display("FAIL stall_pair_count: got %0d required 3", acc_cnt - base);
    end
  endtask

  task automatic test_zero_len();
    int base;
    base = acc_cnt;
    in_valid = 1'b1;
    a_in = 8'd11;
    b_in = 8'd13;
    start_job(0, "zero");
    expect_job();
    collect(1, 0, "zero");
    in_valid = 1'b0;
    checks++;
    if (acc_cnt - base !== 0) begin
      failures++;
      $display("FAIL zero_pair_count: got %0d required 0", acc_cnt - base);
    end
  endtask

  task automatic test_overflow();
    int w;
    start_job(2, "ovf");
    send_pair(255, 255, w, "ovf");
    send_pair(255, 255, w, "ovf");
    expect_job();
    collect(2, 0, "ovf");
    start_job(1, "ovf_clear");
    send_pair(2, 2, w, "ovf_clear");
    expect_job();
    collect(2, 0, "ovf_clear");
  endtask

  task automatic test_ignored_start();
    int w;
    start_job(2, "ign");
    send_pair(6, 7, w, "ign");
    start = 1'b1;
    len = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    len = '0;
    send_pair(9, 10, w, "ign");
    expect_job();
    collect(2, 0, "ign");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL ign_no_second_job%0d: busy=%b required 0", i, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int n;
    int av;
    int bv;
    n = 5;
    start_job(n, "b2b");
    for (int i = 0; i < n; i++) begin
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      send_pair(av, bv, w, "b2b");
      checks++;
      if (w !== 0) begin
        failures++;
        $display("FAIL b2b_stall%0d: waited %0d cycles required 0", i, w);
      end
    end
    expect_job();
    collect(2, 0, "b2b");
  endtask

  // ---------------- sequence and report ----------------

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_stall_backpressure();
    test_zero_len();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL leftover_expectations: got %0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the MAC unit. It accepts a job of LEN operand pairs and pulls them through a valid/ready stream. Each pair is multiplied in a registered product stage and added into an accumulator. The final sum is presented on a held valid/ready result port. It sits between the operand source (memory/host interface) and the result consumer, and owns all start/clear/enable sequencing of the multiply-accumulate datapath.

## Interface
- WIDTH, 8: operand width (A, B), unsigned
- ACC_WIDTH, 16: accumulator/RESULT width; must be ≥ 2*WIDTH
- LEN_WIDTH, 4: width of job length LEN
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  job request; sampled only in IDLE
- LEN  in  LEN_WIDTH  number of pairs in the job; captured with START
- BUSY  out  1  high in every state except IDLE
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  controller can accept a pair
- A, B  in  WIDTH  operand pair
- OUT_VALID  out  1  RESULT valid
- OUT_READY  in  1  consumer accepts RESULT
- RESULT  out  ACC_WIDTH  accumulated sum
- OVF  out  1  sticky accumulator overflow for current/last job

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE; ACC, P_REG, P_VLD, count, OVF, OUT_VALID all 0.
- IDLE, START=1, LEN≠0: clear ACC, OVF, count; capture LEN; → RUN.
- IDLE, START=1, LEN=0: clear ACC, OVF; → DONE directly (RESULT=0).
- START outside IDLE is ignored (no effect on LEN, ACC, OVF).
- RUN: IN_READY=1. A pair is accepted on an edge with IN_VALID && IN_READY.
  - On accept: P_REG ← A*B (2*WIDTH bits, unsigned); P_VLD ← 1; count ← count+1.
  - Without accept: P_VLD ← 0.
  - On the accept where count+1 == LEN: → DRAIN.
- On every edge with P_VLD=1 (any state): ACC ← ACC + zero-extended P_REG, modulo 2^ACC_WIDTH. Carry-out sets OVF (sticky until next accepted START).
- DRAIN: IN_READY=0. Exactly one cycle, the final product is added; P_VLD ← 0; → DONE.
- DONE: OUT_VALID=1, RESULT=ACC held stable, IN_READY=0.
  - On OUT_VALID && OUT_READY: → IDLE, OUT_VALID ← 0. ACC and OVF keep their values until the next START.
- IN_READY is 0 in IDLE, DRAIN and DONE. Pairs offered there are not consumed.
- RESULT always drives ACC. It is meaningful only while OUT_VALID=1.
- Asserting RST_N low in any state aborts the job immediately: outputs return to reset values asynchronously, and any partial sum is lost.

## Timing
- START accepted at edge k0 → BUSY=1 and IN_READY=1 after k0. The first pair can be accepted at edge k0+1.
- Back-to-back: one pair per cycle when IN_VALID is held high. Gaps in IN_VALID stall the job without error.
- Last pair accepted at edge k → DRAIN after k. Final add at k+1 → DONE and OUT_VALID=1 after k+1.
- Latency from last accept to result: 2 edges.
- LEN=0: START at k0 → OUT_VALID=1 after k0.
- Minimum job turnaround (LEN=n, no stalls, OUT_READY=1): n+3 edges from START accept back to IDLE.
- A new START can be accepted on the first edge where the state is IDLE, i.e. one cycle after the result handshake.

## Test plan
- Reset check: hold RST_N=0 for 3 cycles → BUSY=0, IN_READY=0, OUT_VALID=0, RESULT=0, OVF=0. Repeat with RST_N asserted mid-RUN → same values immediately. Next job then runs correctly.
- Basic job: START with LEN=3, pairs (3,4),(5,6),(7,8) back-to-back → OUT_VALID exactly 2 edges after the third accept, RESULT=98, OVF=0.
- Stalls and backpressure: LEN=3, same pairs with IN_VALID low for 2 cycles between each pair, and OUT_READY low for 4 cycles in DONE → RESULT=98 held stable, OUT_VALID held high, no extra pairs consumed.
- Zero length: START with LEN=0 → OUT_VALID after 1 edge, RESULT=0. IN_READY stays 0 throughout.
- Overflow: LEN=2, pairs (255,255),(255,255) → RESULT=64514 (130050 mod 65536), OVF=1. A following job LEN=1, pair (2,2) → RESULT=4, OVF=0.
- Ignored START: pulse START during RUN with LEN=1 on a LEN=2 job → job still completes after 2 pairs with the correct sum; the ignored START launches no second job.
